// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Assembles a little-endian byte stream into 32-bit words and
//            writes them to sequential word addresses of the instruction store.
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int unsigned SIZE      = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [15:0] i_length,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] c_SIZE = SIZE[31:0];

    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic [15:0] r_index;
    logic [15:0] r_length;

    logic        w_too_long;
    logic        w_last_word;
    logic [31:0] w_word_addr;

    assign w_too_long  = ({16'd0, i_length} > c_SIZE);
    assign w_last_word = ((r_index + 16'd1) == r_length);
    assign w_word_addr = BASE_ADDR + {14'd0, r_index, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= 2'd0;
            r_index      <= 16'd0;
            r_length     <= 16'd0;
            o_byte_ready <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= BASE_ADDR;
            o_mem_wdata  <= 32'd0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_mem_we <= 1'b0;
            o_done   <= 1'b0;
            o_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_length == 16'd0) begin
                            r_state <= S_DONE;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b1;
                        end else if (w_too_long) begin
                            o_error <= 1'b1;
                        end else begin
                            r_length     <= i_length;
                            r_index      <= 16'd0;
                            r_byte_cnt   <= 2'd0;
                            r_state      <= S_RECV;
                            o_byte_ready <= 1'b1;
                            o_busy       <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    // o_byte_ready is high throughout RECV, so valid alone means a transfer
                    if (i_byte_valid) begin
                        o_mem_wdata[{r_byte_cnt, 3'b000} +: 8] <= i_byte_in;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state      <= S_WRITE;
                            o_byte_ready <= 1'b0;
                            o_mem_we     <= 1'b1;
                            o_mem_addr   <= w_word_addr;
                        end
                    end
                end
                S_WRITE: begin
                    r_index    <= r_index + 16'd1;
                    r_byte_cnt <= 2'd0;
                    if (w_last_word) begin
                        r_state <= S_DONE;
                        o_done  <= 1'b1;
                    end else begin
                        r_state      <= S_RECV;
                        o_byte_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    o_busy       <= 1'b0;
                    o_byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed-sequence bench for imem_loader with random payloads
//            checked against an expected-word model built from the byte list.
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

    localparam logic [31:0] c_BASE = 32'h0000_0000;
    localparam int          c_SIZE = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_length = 16'd0;
    logic [7:0]  i_byte_in = 8'd0;
    logic        i_byte_valid = 1'b0;
    logic        o_byte_ready;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [7:0] tx[$];
    logic [7:0] acc_q[$];

    imem_loader #(.SIZE(c_SIZE), .BASE_ADDR(c_BASE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_length     (i_length),
        .i_byte_in    (i_byte_in),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    // Event monitor: inputs are stable around the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_mem_we) wr_cnt++;
            if (o_done) done_cnt++;
            if (o_error) err_cnt++;
            if (i_byte_valid && o_byte_ready) acc_q.push_back(i_byte_in);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_tx(input int nbytes);
        tx.delete();
        for (int i = 0; i < nbytes; i++) tx.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        i_byte_in    = b;
        i_byte_valid = 1'b1;
        while (o_byte_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(o_byte_ready), 32'd1);
        step();
    endtask

    // Full load of len words from tx[], with gap idle cycles before each byte.
    // mid_start >= 0 pulses start (length 5) before that byte index.
    task automatic run_load(input int len, input int gap, input int mid_start);
        int wr0 = wr_cnt;
        int dn0 = done_cnt;
        logic [31:0] exp_word;
        logic [31:0] exp_addr;
        acc_q.delete();
        i_start  = 1'b1;
        i_length = 16'(len);
        step();
        i_start = 1'b0;
        for (int k = 0; k < len * 4; k++) begin
            if (k == mid_start) begin
                i_byte_valid = 1'b0;
                i_start      = 1'b1;
                i_length     = 16'd5;
                step();
                i_start = 1'b0;
            end
            if (gap > 0) begin
                i_byte_valid = 1'b0;
                repeat (gap) step();
            end
            send_byte(tx[k]);
            if (k % 4 == 3) begin
                exp_word = {tx[k], tx[k-1], tx[k-2], tx[k-3]};
                exp_addr = c_BASE + 32'((k / 4) * 4);
                chk("write_we", 32'(o_mem_we), 32'd1);
                chk("write_addr", o_mem_addr, exp_addr);
                chk("write_data", o_mem_wdata, exp_word);
                chk("write_ready_low", 32'(o_byte_ready), 32'd0);
            end
        end
        i_byte_valid = 1'b0;
        step();
        chk("done_pulse", 32'(o_done), 32'd1);
        chk("done_we_low", 32'(o_mem_we), 32'd0);
        step();
        chk("busy_after_done", 32'(o_busy), 32'd0);
        chk("done_single", 32'(o_done), 32'd0);
        chk("addr_held", o_mem_addr, c_BASE + 32'((len - 1) * 4));
        chk("write_count", 32'(wr_cnt - wr0), 32'(len));
        chk("done_count", 32'(done_cnt - dn0), 32'd1);
        chk("bytes_accepted", 32'(acc_q.size()), 32'(len * 4));
        for (int i = 0; i < acc_q.size() && i < tx.size(); i++) begin
            if (acc_q[i] !== tx[i]) chk("byte_order", 32'(acc_q[i]), 32'(tx[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
        chk({tag, "_we"}, 32'(o_mem_we), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_error"}, 32'(o_error), 32'd0);
        chk({tag, "_addr"}, o_mem_addr, c_BASE);
        chk({tag, "_wdata"}, o_mem_wdata, 32'd0);
    endtask

    initial begin
        int wr0;
        int dn0;

        // Reset then idle, with a byte offered the whole time.
        i_byte_valid = 1'b1;
        i_byte_in    = 8'hA5;
        repeat (3) step();
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        repeat (3) step();
        check_reset_outputs("idle");
        chk("idle_no_writes", 32'(wr_cnt), 32'd0);
        i_byte_valid = 1'b0;

        // Two-word load, no stalls.
        tx = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(2, 0, -1);

        // Same load with three idle cycles before every byte.
        run_load(2, 3, -1);

        // Random payload, random gaps.
        fill_tx(4 * 6);
        run_load(6, int'($urandom_range(0, 2)), -1);

        // length 0: straight to done, no write.
        wr0 = wr_cnt;
        i_start  = 1'b1;
        i_length = 16'd0;
        step();
        i_start = 1'b0;
        chk("len0_done", 32'(o_done), 32'd1);
        chk("len0_busy", 32'(o_busy), 32'd1);
        step();
        chk("len0_done_clear", 32'(o_done), 32'd0);
        chk("len0_idle", 32'(o_busy), 32'd0);
        chk("len0_no_write", 32'(wr_cnt - wr0), 32'd0);

        // length SIZE+1: rejected.
        wr0 = wr_cnt;
        i_start  = 1'b1;
        i_length = 16'(c_SIZE + 1);
        i_byte_valid = 1'b1;
        step();
        i_start = 1'b0;
        chk("over_error", 32'(o_error), 32'd1);
        chk("over_busy", 32'(o_busy), 32'd0);
        chk("over_ready", 32'(o_byte_ready), 32'd0);
        step();
        chk("over_error_clear", 32'(o_error), 32'd0);
        chk("over_no_write", 32'(wr_cnt - wr0), 32'd0);
        i_byte_valid = 1'b0;

        // length SIZE: legal, last write at BASE + 4*(SIZE-1).
        fill_tx(4 * c_SIZE);
        run_load(c_SIZE, 0, -1);
        chk("full_last_addr", o_mem_addr, c_BASE + 32'h0000_03FC);

        // start during a load is ignored.
        fill_tx(4);
        run_load(1, 0, 2);
        repeat (3) step();
        chk("midstart_idle", 32'(o_busy), 32'd0);
        chk("midstart_error", 32'(err_cnt), 32'd1);

        // Reset in the middle of word 1 of a three-word load.
        fill_tx(12);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        i_start  = 1'b1;
        i_length = 16'd3;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 6; k++) send_byte(tx[k]);
        chk("prereset_busy", 32'(o_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        i_byte_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset_we", 32'(o_mem_we), 32'd0);
        chk("partial_writes", 32'(wr_cnt - wr0), 32'd1);
        chk("partial_no_done", 32'(done_cnt - dn0), 32'd0);
        fill_tx(4);
        run_load(1, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
